// File: rtl/decode_stage_ctrl.sv
// Fetch->decode controller: 2-entry skid FIFO between fetch and decode, with
// load-use bubble insertion against execute and flush on redirect.
module decode_stage_ctrl #(
    parameter int                IWIDTH   = 32,
    parameter int                AWIDTH   = 32,
    parameter int                CNTW     = 16,
    parameter logic [IWIDTH-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [IWIDTH-1:0] if_inst,
    input  logic [AWIDTH-1:0] if_pc,
    output logic              if_ready,
    output logic              id_valid,
    output logic [IWIDTH-1:0] id_inst,
    output logic [AWIDTH-1:0] id_pc,
    input  logic              id_ready,
    input  logic              flush,
    input  logic              ex_load,
    input  logic [4:0]        ex_rd,
    output logic [CNTW-1:0]   stall_cnt
);

    logic [IWIDTH-1:0] inst_q [2];
    logic [IWIDTH-1:0] inst_d [2];
    logic [AWIDTH-1:0] pc_q   [2];
    logic [AWIDTH-1:0] pc_d   [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q,  count_d;
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [IWIDTH-1:0] head_inst;
    logic [AWIDTH-1:0] head_pc;
    logic [6:0]        opcode;
    logic [4:0]        rs1, rs2;
    logic              use_rs1, use_rs2, hazard, not_empty, push, pop;

    always_comb begin
        head_inst = inst_q[rd_ptr_q];
        head_pc   = pc_q[rd_ptr_q];
        opcode    = head_inst[6:0];
        rs1       = head_inst[19:15];
        rs2       = head_inst[24:20];
        use_rs1   = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
        use_rs2   = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
        hazard    = ex_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
        not_empty = (count_q != 2'd0);

        // rst_n gates the handshakes so nothing is offered or taken while reset is held
        if_ready  = rst_n && (count_q != 2'd2) && !flush;
        id_valid  = rst_n && not_empty && !hazard && !flush;
        id_inst   = id_valid ? head_inst : NOP_INST;
        id_pc     = id_valid ? head_pc   : '0;
        stall_cnt = stall_cnt_q;

        push = if_valid && if_ready;
        pop  = id_valid && id_ready;

        inst_d   = inst_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            inst_d[wr_ptr_q] = if_inst;
            pc_d[wr_ptr_q]   = if_pc;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (not_empty && hazard && !flush && (stall_cnt_q != {CNTW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload storage needs no reset: count=0 already marks it as dead.
    always_ff @(posedge clk) begin
        inst_q <= inst_d;
        pc_q   <= pc_d;
    end

endmodule
